// File: rtl/ntt_address_generator_if.sv
// Operand-address bus between the NTT address generator and the conflict-free memory map.
// Signal names match the memory map's address inputs.
interface ntt_address_generator_if #(
  parameter int LOGN = 10
);
  logic            start;
  logic            stall;
  logic [LOGN-1:0] old_address_0;
  logic [LOGN-1:0] old_address_1;
  logic [LOGN-1:0] old_address_2;
  logic [LOGN-1:0] old_address_3;
  logic [LOGN-2:0] tw_idx_0;
  logic [LOGN-2:0] tw_idx_1;
  logic [3:0]      stage;
  logic            addr_valid;
  logic            busy;
  logic            done;

  modport slave (
    input  start, stall,
    output old_address_0, old_address_1, old_address_2, old_address_3,
           tw_idx_0, tw_idx_1, stage, addr_valid, busy, done
  );

  modport master (
    output start, stall,
    input  old_address_0, old_address_1, old_address_2, old_address_3,
           tw_idx_0, tw_idx_1, stage, addr_valid, busy, done
  );
endinterface

// File: rtl/ntt_address_generator.sv
// Butterfly address/twiddle sequencer for an in-place radix-2 Cooley-Tukey NTT on two BFUs.
// Each RUN cycle issues butterflies j=2c and j=2c+1 of stage s.
module ntt_address_generator #(
  parameter int LOGN = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  ntt_address_generator_if.slave  bus
);
  localparam int CW = LOGN - 2;
  localparam logic [CW-1:0]   C_ONE = CW'(1);
  localparam logic [LOGN-1:0] ONE   = LOGN'(1);
  localparam logic [LOGN-2:0] ONE_S = (LOGN-1)'(1);
  localparam logic [3:0]      S_LAST = 4'(LOGN - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  state_e        fsm_q;
  logic [3:0]    s_q;
  logic [CW-1:0] c_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      s_q   <= '0;
      c_q   <= '0;
    end else begin
      case (fsm_q)
        IDLE: if (bus.start) begin
          fsm_q <= RUN;
          s_q   <= '0;
          c_q   <= '0;
        end
        RUN: if (!bus.stall) begin
          c_q <= c_q + C_ONE;
          if (&c_q) begin
            // Park the stage counter at 0 once the last stage is done.
            if (s_q == S_LAST) begin
              fsm_q <= FINISH;
              s_q   <= '0;
            end else begin
              s_q <= s_q + 4'd1;
            end
          end
        end
        FINISH:  fsm_q <= IDLE;
        default: fsm_q <= IDLE;
      endcase
    end
  end

  logic            run;
  logic [LOGN-1:0] dbit;
  logic [LOGN-2:0] mask;
  logic [3:0]      tw_sh;
  logic [LOGN-2:0] j_w  [2];
  logic [LOGN-2:0] k_w  [2];
  logic [LOGN-2:0] tw_w [2];
  logic [LOGN-1:0] a_w  [2];
  logic [LOGN-1:0] b_w  [2];

  // A inserts a zero at bit s of j; B sets that bit. Mask wraps to all ones at the last stage.
  always_comb begin
    run   = (fsm_q == RUN);
    dbit  = ONE << s_q;
    mask  = dbit[LOGN-2:0] - ONE_S;
    tw_sh = S_LAST - s_q;
    for (int n = 0; n < 2; n++) begin
      j_w[n]  = {c_q, 1'(n)};
      k_w[n]  = j_w[n] & mask;
      a_w[n]  = ({1'b0, j_w[n] & ~mask} << 1) | {1'b0, k_w[n]};
      b_w[n]  = a_w[n] | dbit;
      tw_w[n] = k_w[n] << tw_sh;
    end
  end

  assign bus.old_address_0 = run ? a_w[0]  : '0;
  assign bus.old_address_1 = run ? b_w[0]  : '0;
  assign bus.old_address_2 = run ? a_w[1]  : '0;
  assign bus.old_address_3 = run ? b_w[1]  : '0;
  assign bus.tw_idx_0      = run ? tw_w[0] : '0;
  assign bus.tw_idx_1      = run ? tw_w[1] : '0;
  assign bus.stage         = s_q;
  assign bus.addr_valid    = run & ~bus.stall;
  assign bus.busy          = (fsm_q != IDLE);
  assign bus.done          = (fsm_q == FINISH);
endmodule

// File: tb/tb_ntt_address_generator.sv
// Directed bench for ntt_address_generator: reset, full-sequence spot vectors, per-stage
// coverage, stall, ignored restart, mid-run reset and back-to-back transforms.
module tb_ntt_address_generator;
  localparam int LOGN = 10;
  localparam int CPS  = 256;
  localparam int TOT  = 2560;
  localparam int NV   = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ntt_address_generator_if #(.LOGN(LOGN)) bus();
  ntt_address_generator #(.LOGN(LOGN)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int          s;
    int          c;
    logic [57:0] exp;
  } vec_t;

  vec_t vecs [NV];
  int   seen [LOGN][1024];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [57:0] pk(input int a0, a1, a2, a3, t0, t1);
    return {10'(a0), 10'(a1), 10'(a2), 10'(a3), 9'(t0), 9'(t1)};
  endfunction

  function automatic logic [57:0] tup();
    return {bus.old_address_0, bus.old_address_1, bus.old_address_2, bus.old_address_3,
            bus.tw_idx_0, bus.tw_idx_1};
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, bus.addr_valid, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_stage"}, bus.stage, 0);
    chk({nm, "_tuple"}, tup(), 0);
  endtask

  // Issues start, then follows the transform until done. abort_at>=0 applies rst at that tuple.
  task automatic run(input bit do_stall, input bit do_restart, input int abort_at);
    int vcount = 0, stall_left = 0, last_vcyc = -2, hits = 0;
    int bad_seq = 0, bad_diff = 0, s, c;
    bit stalled = 0, restarted = 0, got_done = 0, extra_done;
    for (int i = 0; i < LOGN; i++) for (int a = 0; a < 1024; a++) seen[i][a] = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 4000 && !got_done; cyc++) begin
      bus.start = 1'b0;
      bus.stall = 1'b0;
      if (do_stall && !stalled && vcount == 2*CPS + 10) begin stall_left = 4; stalled = 1; end
      if (stall_left > 0) bus.stall = 1'b1;
      if (do_restart && !restarted && vcount == 4*CPS + 3) begin bus.start = 1'b1; restarted = 1; end
      if (abort_at >= 0 && vcount == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk_idle("rst_mid");
        extra_done = 0;
        repeat (5) begin
          @(posedge clk); #1;
          if (bus.done || bus.busy) extra_done = 1;
        end
        chk("rst_no_done", extra_done, 0);
        return;
      end
      #1;
      if (cyc == 0) chk("first_latency", bus.addr_valid, 1);
      if (stall_left > 0) begin
        chk("stall_valid", bus.addr_valid, 0);
        chk("stall_frozen", tup(), pk(40, 44, 41, 45, 0, 128));
        stall_left--;
      end else if (bus.addr_valid) begin
        s = vcount / CPS;
        c = vcount % CPS;
        if (bus.stage != 4'(s) || !bus.busy || bus.done) bad_seq++;
        if (int'(bus.old_address_1) - int'(bus.old_address_0) != (1 << s) ||
            int'(bus.old_address_3) - int'(bus.old_address_2) != (1 << s)) bad_diff++;
        if (s < LOGN) begin
          seen[s][bus.old_address_0]++;
          seen[s][bus.old_address_1]++;
          seen[s][bus.old_address_2]++;
          seen[s][bus.old_address_3]++;
        end
        for (int v = 0; v < NV; v++)
          if (vecs[v].s == s && vecs[v].c == c) begin
            hits++;
            chk($sformatf("tuple_s%0d_c%0d", s, c), tup(), vecs[v].exp);
          end
        vcount++;
        last_vcyc = cyc;
      end else if (bus.done) begin
        got_done = 1;
        chk("valid_total", vcount, TOT);
        chk("done_follows_last", last_vcyc, cyc - 1);
        chk("done_busy", bus.busy, 1);
      end else begin
        bad_seq++;
      end
      @(posedge clk); #1;
    end
    chk("done_seen", got_done, 1);
    chk("stage_sequence", bad_seq, 0);
    chk("pair_stride", bad_diff, 0);
    chk("vec_hits", hits, NV);
    for (int i = 0; i < LOGN; i++) begin
      int once = 0;
      for (int a = 0; a < 1024; a++) if (seen[i][a] == 1) once++;
      chk($sformatf("coverage_s%0d", i), once, 1024);
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    #1;
    chk("done_one_cycle", bus.done, 0);
    chk("busy_after_done", bus.busy, 0);
    chk("valid_after_done", bus.addr_valid, 0);
  endtask

  initial begin
    vecs[0] = '{0, 0,   pk(0, 1, 2, 3, 0, 0)};
    vecs[1] = '{0, 7,   pk(28, 29, 30, 31, 0, 0)};
    vecs[2] = '{1, 0,   pk(0, 2, 1, 3, 0, 256)};
    vecs[3] = '{2, 10,  pk(40, 44, 41, 45, 0, 128)};
    vecs[4] = '{2, 11,  pk(42, 46, 43, 47, 256, 384)};
    vecs[5] = '{3, 5,   pk(18, 26, 19, 27, 128, 192)};
    vecs[6] = '{5, 100, pk(392, 424, 393, 425, 128, 144)};
    vecs[7] = '{8, 128, pk(512, 768, 513, 769, 0, 2)};
    vecs[8] = '{9, 0,   pk(0, 512, 1, 513, 0, 1)};
    vecs[9] = '{9, 255, pk(510, 1022, 511, 1023, 510, 511)};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("in_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_idle("after_reset");

    run(1'b0, 1'b0, -1);            // free run
    run(1'b1, 1'b1, -1);            // back-to-back start, stall at (2,10), restart ignored
    run(1'b0, 1'b0, 6*CPS + 20);    // reset mid stage 6
    run(1'b0, 1'b0, -1);            // fresh transform after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
